id_hazard_ctl: RTL and testbench
================================

Name: id_hazard_ctl

Overview:
- Pipeline control block consuming the decode-side fields presented to the ID/EX boundary and the EX-stage resolution signals.
- Drives stall and flush controls back into the IF/ID and ID/EX pipeline registers.
- Keeps a 3-slot destination scoreboard (EX, MEM, WB) to detect RAW hazards; no forwarding paths are provided.
- Sequences halt draining after a createdump instruction.

Parameters:
- NUM_SLOTS, 3, scoreboard depth (EX, MEM, WB).
- WB_BYPASS, 1, 1 = register file writes before it reads, so the WB slot never causes a hazard.
- DRAIN_CYCLES, 3, non-frozen cycles held in DRAIN before asserting halt.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  3  source register 1 index.
- id_rs_used  in  1  instruction reads rs.
- id_rt  in  3  source register 2 index.
- id_rt_used  in  1  instruction reads rt.
- id_rd  in  3  destination register index.
- id_reg_write  in  1  instruction writes rd.
- id_memRead  in  1  instruction is a load.
- id_createdump  in  1  instruction is halt/createdump.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- mem_stall  in  1  data memory busy; freeze the whole pipeline.
- if_stall  out  1  hold PC and IF/ID.
- id_stall  out  1  hold ID inputs (same value as if_stall).
- ifid_flush  out  1  load NOP into IF/ID.
- idex_flush  out  1  load bubble into ID/EX.
- halt  out  1  processor halted.
- stall_count  out  16  saturating count of hazard-stall cycles.

Behaviour:
- Reset (rst=0 at a clock edge):
  - All scoreboard slots invalid; FSM to RUN; drain counter 0; stall_count 0.
  - All outputs 0.
- Reset mid-drain or in HALT returns to RUN with an empty scoreboard.
- Scoreboard slot fields: {valid, dest[2:0], is_load}.
- hazard = id_valid && the FSM is in RUN && for some used source, src == dest of a valid slot.
  - Slots checked are EX and MEM.
  - The WB slot is also checked only when WB_BYPASS=0.
- Per-cycle priority, highest first:
  1. mem_stall=1: if_stall=id_stall=1, no flushes. Scoreboard, FSM, drain counter and stall_count all hold.
  2. ex_branch_taken=1: ifid_flush=idex_flush=1, if_stall=0. Scoreboard shifts (EX->MEM->WB, WB drops out) with an invalid entry into EX. An id_createdump present this cycle is squashed, so no FSM transition.
  3. hazard: if_stall=id_stall=1, idex_flush=1. Scoreboard shifts with an invalid entry into EX. stall_count increments, saturating at 16'hFFFF.
  4. Otherwise: no stall or flush. Scoreboard shifts with {id_valid&&id_reg_write, id_rd, id_memRead} entering EX.
- Outputs are combinational from the current state and inputs; the scoreboard updates on the clock edge (zero-latency stall decision).
- Load-use case: a load in EX with a matching source stalls 2 cycles (EX, then MEM). The same applies to ALU producers, since there is no forwarding.
- FSM:
  - RUN -> DRAIN when case 4 fires with id_valid && id_createdump. The drain counter clears to 0.
  - DRAIN: if_stall=id_stall=1 and idex_flush=1 every cycle. The counter increments on each non-mem_stall cycle. Go to HALT when counter == DRAIN_CYCLES-1 and mem_stall=0.
  - In DRAIN, ex_branch_taken is ignored: older instructions are already past EX by construction.
  - HALT: halt=1, if_stall=id_stall=1, flushes 0. Held until reset.
- Simultaneous mem_stall and ex_branch_taken: mem_stall wins. The branch is re-presented by EX on the next unfrozen cycle.

Decomposition:
- Shared package holds:
  - Register index width constant REG_IDX_W=3.
  - Scoreboard entry typedef {valid, dest, is_load}.
  - FSM state encoding RUN=2'b00, DRAIN=2'b01, HALT=2'b10.
- One natural sub-module: hazard_scoreboard. It holds the shift-register slots, hold/shift/bubble control, and the match compare outputs.

Test Plan:
- Reset: rst=0 for 2 cycles with random inputs -> all outputs 0, stall_count=0. Release: id_valid=1, no hazards -> no stall.
- ALU RAW: cycle0 ID writes r3 (accepted); cycle1 ID reads rs=r3 -> if_stall=idex_flush=1 in cycles 1 and 2; cycle 3 no stall; stall_count=2.
- Branch priority: a hazard and ex_branch_taken=1 in the same cycle -> ifid_flush=idex_flush=1, if_stall=0, stall_count unchanged.
- mem_stall freeze: during the r3 hazard stall, assert mem_stall for 4 cycles -> no flushes, stall_count frozen. The hazard resumes afterwards, with 2 total counted stall cycles.
- Halt drain: createdump accepted -> 3 DRAIN cycles with stall+flush, then halt=1 held. rst=0 -> halt=0 and state RUN.
- Squashed halt: id_createdump with ex_branch_taken=1 -> FSM stays RUN, halt remains 0.

Source files
------------

// File: rtl/id_hazard_ctl_pkg.sv
// Shared types for the ID-stage hazard controller: register index width,
// scoreboard slot layout and controller state encoding.
package id_hazard_ctl_pkg;

    localparam int REG_IDX_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] dest;
        logic                 is_load;
    } sb_entry_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_HALT  = 2'b10
    } ctl_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Destination shift register (EX, MEM, WB) with per-slot source compares.
// Slot 0 is EX; the last slot is WB.
module hazard_scoreboard
    import id_hazard_ctl_pkg::*;
#(
    parameter int NUM_SLOTS = 3,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic                 bubble,
    input  sb_entry_t            new_entry,
    input  logic [REG_IDX_W-1:0] rs,
    input  logic                 rs_used,
    input  logic [REG_IDX_W-1:0] rt,
    input  logic                 rt_used,
    output logic                 match
);

    sb_entry_t              slots_reg [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   slot_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots_reg[i] <= '0;
            end
        end else if (!hold) begin
            for (int i = NUM_SLOTS - 1; i > 0; i--) begin
                slots_reg[i] <= slots_reg[i-1];
            end
            slots_reg[0] <= bubble ? '0 : new_entry;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_cmp
            if (WB_BYPASS && (gi == NUM_SLOTS - 1)) begin : g_bypassed
                // Register file writes before it reads, so WB never conflicts.
                assign slot_hit[gi] = 1'b0;
            end else begin : g_checked
                assign slot_hit[gi] = slots_reg[gi].valid &&
                    ((rs_used && (rs == slots_reg[gi].dest)) ||
                     (rt_used && (rt == slots_reg[gi].dest)));
            end
        end
    endgenerate

    assign match = |slot_hit;

endmodule

// File: rtl/id_hazard_ctl.sv
// Stall/flush control for IF/ID and ID/EX with RAW detection (no forwarding)
// and createdump halt draining.
module id_hazard_ctl
    import id_hazard_ctl_pkg::*;
#(
    parameter int NUM_SLOTS    = 3,
    parameter bit WB_BYPASS    = 1'b1,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic                 id_rs_used,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_rt_used,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_reg_write,
    input  logic                 id_memRead,
    input  logic                 id_createdump,
    input  logic                 ex_branch_taken,
    input  logic                 mem_stall,
    output logic                 if_stall,
    output logic                 id_stall,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 halt,
    output logic [15:0]          stall_count
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES) + 1;

    ctl_state_t         state_reg, state_next;
    logic [DRAIN_W-1:0] drain_cnt_reg, drain_cnt_next;
    logic [15:0]        stall_count_reg, stall_count_next;

    logic      sb_hold, sb_bubble, sb_match, hazard;
    sb_entry_t sb_new;

    assign sb_new = '{valid: id_valid && id_reg_write, dest: id_rd, is_load: id_memRead};

    hazard_scoreboard #(
        .NUM_SLOTS (NUM_SLOTS),
        .WB_BYPASS (WB_BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .hold      (sb_hold),
        .bubble    (sb_bubble),
        .new_entry (sb_new),
        .rs        (id_rs),
        .rs_used   (id_rs_used),
        .rt        (id_rt),
        .rt_used   (id_rt_used),
        .match     (sb_match)
    );

    assign hazard = id_valid && (state_reg == ST_RUN) && sb_match;

    always_comb begin
        if_stall         = 1'b0;
        ifid_flush       = 1'b0;
        idex_flush       = 1'b0;
        halt             = 1'b0;
        sb_hold          = 1'b0;
        sb_bubble        = 1'b1;
        state_next       = state_reg;
        drain_cnt_next   = drain_cnt_reg;
        stall_count_next = stall_count_reg;

        // Outputs stay quiet while reset is asserted, whatever the inputs do.
        if (rst) begin
            unique case (state_reg)
                ST_RUN: begin
                    if (mem_stall) begin
                        if_stall = 1'b1;
                        sb_hold  = 1'b1;
                    end else if (ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (hazard) begin
                        if_stall   = 1'b1;
                        idex_flush = 1'b1;
                        if (stall_count_reg != 16'hFFFF) begin
                            stall_count_next = stall_count_reg + 16'd1;
                        end
                    end else begin
                        sb_bubble = 1'b0;
                        if (id_valid && id_createdump) begin
                            state_next     = ST_DRAIN;
                            drain_cnt_next = '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if_stall = 1'b1;
                    if (mem_stall) begin
                        sb_hold = 1'b1;
                    end else begin
                        idex_flush     = 1'b1;
                        drain_cnt_next = drain_cnt_reg + 1'b1;
                        if (drain_cnt_reg == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                            state_next = ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    if_stall = 1'b1;
                    halt     = 1'b1;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= ST_RUN;
            drain_cnt_reg   <= '0;
            stall_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            drain_cnt_reg   <= drain_cnt_next;
            stall_count_reg <= stall_count_next;
        end
    end

    assign id_stall    = if_stall;
    assign stall_count = rst ? stall_count_reg : 16'd0;

endmodule

// File: tb/tb_id_hazard_ctl.sv
// Directed-vector bench: each cycle's stimulus pushes its expected outputs;
// a negedge monitor pops and compares.
module tb_id_hazard_ctl;
    import id_hazard_ctl_pkg::*;

    localparam logic [4:0] NONE   = 5'b00000; // {if_stall,id_stall,ifid_flush,idex_flush,halt}
    localparam logic [4:0] STALL  = 5'b11010;
    localparam logic [4:0] FREEZE = 5'b11000;
    localparam logic [4:0] BRANCH = 5'b00110;
    localparam logic [4:0] HALTED = 5'b11001;

    typedef struct {
        string       name;
        logic [4:0]  ctl;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs_used, id_rt_used, id_reg_write, id_memRead, id_createdump;
    logic [2:0]  id_rs, id_rt, id_rd;
    logic        ex_branch_taken, mem_stall;
    logic        if_stall, id_stall, ifid_flush, idex_flush, halt;
    logic [15:0] stall_count;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    id_hazard_ctl dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rs_used      (id_rs_used),
        .id_rt           (id_rt),
        .id_rt_used      (id_rt_used),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_memRead      (id_memRead),
        .id_createdump   (id_createdump),
        .ex_branch_taken (ex_branch_taken),
        .mem_stall       (mem_stall),
        .if_stall        (if_stall),
        .id_stall        (id_stall),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .halt            (halt),
        .stall_count     (stall_count)
    );

    // Fields: name, rst, valid, rs, rs_used, rt, rt_used, rd, reg_write,
    // memRead, createdump, branch, mem_stall, expected ctl, expected count.
    task automatic step(input string name, input logic r, input logic v,
                        input logic [2:0] rs, input logic rsu,
                        input logic [2:0] rt, input logic rtu,
                        input logic [2:0] rd, input logic rw, input logic mr,
                        input logic cd, input logic br, input logic ms,
                        input logic [4:0] ectl, input logic [15:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt;
        id_rt_used = rtu; id_rd = rd; id_reg_write = rw; id_memRead = mr;
        id_createdump = cd; ex_branch_taken = br; mem_stall = ms;
        e.name = name; e.ctl = ectl; e.cnt = ecnt;
        exp_q.push_back(e);
    endtask

    task automatic step_rand_reset(input string name);
        step(name, 1'b0, 1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
             1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), NONE, 16'd0);
    endtask

    // Monitor: compare whatever the DUT presents mid-cycle against the oldest expectation.
    initial begin
        exp_t        e;
        logic [4:0]  got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {if_stall, id_stall, ifid_flush, idex_flush, halt};
                n_checks++;
                if (got !== e.ctl || stall_count !== e.cnt) begin
                    n_fails++;
                    $display("FAIL %s: got ctl=%b count=%0d, expected ctl=%b count=%0d",
                             e.name, got, stall_count, e.ctl, e.cnt);
                end else begin
                    $display("[%0t] %s ctl=%b count=%0d ok", $time, e.name, got, stall_count);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; id_valid = 1'b0; id_rs = '0; id_rs_used = 1'b0; id_rt = '0;
        id_rt_used = 1'b0; id_rd = '0; id_reg_write = 1'b0; id_memRead = 1'b0;
        id_createdump = 1'b0; ex_branch_taken = 1'b0; mem_stall = 1'b0;

        // Reset with random inputs, then release
        step_rand_reset("reset_0");
        step_rand_reset("reset_1");
        //    name          r  v  rs rsu rt rtu rd rw mr cd br ms  ctl     cnt
        step("release",     1, 1, 1, 1,  0, 0,  0, 0, 0, 0, 0, 0, NONE,   0);
        // ALU RAW on r3: stall in EX and MEM, clear once r3 reaches WB
        step("raw_prod",    1, 1, 0, 0,  0, 0,  3, 1, 0, 0, 0, 0, NONE,   0);
        step("raw_ex",      1, 1, 3, 1,  0, 0,  4, 1, 0, 0, 0, 0, STALL,  0);
        step("raw_mem",     1, 1, 3, 1,  0, 0,  4, 1, 0, 0, 0, 0, STALL,  1);
        step("raw_wb",      1, 1, 3, 1,  0, 0,  4, 1, 0, 0, 0, 0, NONE,   2);
        step("idle_0",      1, 0, 4, 1,  4, 1,  0, 0, 0, 0, 0, 0, NONE,   2);
        step("idle_1",      1, 0, 4, 1,  4, 1,  0, 0, 0, 0, 0, 0, NONE,   2);
        step("rt_wb_bypass",1, 1, 0, 0,  4, 1,  0, 0, 0, 0, 0, 0, NONE,   2);
        // Branch beats hazard, then hazard on rt from MEM
        step("br_prod",     1, 1, 0, 0,  0, 0,  5, 1, 1, 0, 0, 0, NONE,   2);
        step("br_vs_haz",   1, 1, 0, 0,  5, 1,  0, 0, 0, 0, 1, 0, BRANCH, 2);
        step("rt_mem_haz",  1, 1, 0, 0,  5, 1,  0, 0, 0, 0, 0, 0, STALL,  2);
        step("rt_wb_clear", 1, 1, 0, 0,  5, 1,  0, 0, 0, 0, 0, 0, NONE,   3);
        // mem_stall freezes an in-progress hazard
        step("ms_prod",     1, 1, 0, 0,  0, 0,  3, 1, 0, 0, 0, 0, NONE,   3);
        step("ms_haz_ex",   1, 1, 3, 1,  0, 0,  0, 0, 0, 0, 0, 0, STALL,  3);
        for (int i = 0; i < 4; i++)
            step($sformatf("ms_freeze_%0d", i), 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, FREEZE, 4);
        step("ms_haz_mem",  1, 1, 3, 1,  0, 0,  0, 0, 0, 0, 0, 0, STALL,  4);
        step("ms_clear",    1, 1, 3, 1,  0, 0,  0, 0, 0, 0, 0, 0, NONE,   5);
        // mem_stall outranks a taken branch; branch retried afterwards
        step("ms_vs_br",    1, 1, 0, 0,  0, 0,  0, 0, 0, 0, 1, 1, FREEZE, 5);
        step("br_retry",    1, 1, 0, 0,  0, 0,  0, 0, 0, 0, 1, 0, BRANCH, 5);
        // createdump squashed by a taken branch
        step("cd_squash",   1, 1, 0, 0,  0, 0,  0, 0, 0, 1, 1, 0, BRANCH, 5);
        step("cd_sq_after", 1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, NONE,   5);
        // createdump accepted: 3 drain cycles (one frozen, one with branch), then halt
        step("cd_accept",   1, 1, 0, 0,  0, 0,  0, 0, 0, 1, 0, 0, NONE,   5);
        step("drain_0",     1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, STALL,  5);
        step("drain_frz",   1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 1, FREEZE, 5);
        step("drain_1_br",  1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 1, 0, STALL,  5);
        step("drain_2",     1, 1, 3, 1,  0, 0,  0, 0, 0, 0, 0, 0, STALL,  5);
        step("halt_0",      1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, HALTED, 5);
        step("halt_1",      1, 1, 3, 1,  0, 0,  0, 0, 0, 1, 1, 1, HALTED, 5);
        // Reset from HALT returns to RUN with an empty scoreboard
        step("halt_reset",  0, 1, 3, 1,  0, 0,  0, 0, 0, 0, 0, 0, NONE,   0);
        step("run_again",   1, 1, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0, NONE,   0);
        step("sb_empty",    1, 1, 3, 1,  3, 1,  0, 0, 0, 0, 0, 0, NONE,   0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain_queue: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
